// File: rtl/strided_convolver.sv
// Purpose: KxK signed convolution over an NxN raster stream with stride S; weights loaded serially before each run.
// Latency: a window's result appears 2 cycles after its bottom-right pixel is accepted.
// Backpressure: in_ready low while loading weights or draining for a reload; stalls on in_valid only pause the counters.
module strided_convolver #(
    parameter int N  = 10,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int DW = 16,
    localparam int OW = 2*DW + $clog2(K*K)
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          w_valid,
    input  logic [DW-1:0] w_data,
    input  logic          w_reload,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [OW-1:0] conv_op,
    output logic          valid_conv,
    output logic          end_conv
);

    localparam int KK   = K*K;
    localparam int L    = (K-1)*N + K;      // pixels spanned by one window in raster order
    localparam int CW   = $clog2(N);
    localparam int IW   = $clog2(KK);
    localparam int LAST = ((N-K)/S)*S;      // top-left row/col of the final window

    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_w_idx;
    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic                  r_reload_pend;
    logic                  r_v0, r_e0, r_v1, r_e1;
    logic signed [DW-1:0]  r_wgt  [KK];
    logic signed [DW-1:0]  r_buf  [L];
    logic signed [2*DW-1:0] r_prod [KK];

    logic                  w_accept;
    logic                  w_frame_start;
    logic                  w_drained;
    logic                  w_win_vld;
    logic                  w_win_last;
    int                    w_top_r;
    int                    w_top_c;
    logic signed [OW-1:0]  w_sum;

    assign w_frame_start = (r_row == '0) && (r_col == '0);
    assign w_drained     = !r_v0 && !r_v1;
    // A pending reload blocks new pixels as soon as the frame boundary is reached.
    assign in_ready      = (r_state == ST_RUN) && !(r_reload_pend && w_frame_start);
    assign w_accept      = in_valid && in_ready;

    // Decide whether the incoming pixel completes a legal strided window.
    always_comb begin
        w_top_r    = int'(r_row) - (K-1);
        w_top_c    = int'(r_col) - (K-1);
        w_win_vld  = (w_top_r >= 0) && (w_top_c >= 0) &&
                     (w_top_r <= N-K) && (w_top_c <= N-K) &&
                     ((w_top_r % S) == 0) && ((w_top_c % S) == 0);
        w_win_last = w_win_vld && (w_top_r == LAST) && (w_top_c == LAST);
    end

    // Full-precision sign-extended sum of the registered products.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < KK; k++) begin
            w_sum = w_sum + {{(OW-2*DW){r_prod[k][2*DW-1]}}, r_prod[k]};
        end
    end

    // Control state: LOAD/RUN, weight index, raster counters, reload request, result pipeline.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            r_state       <= ST_LOAD;
            r_w_idx       <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_reload_pend <= 1'b0;
            r_v0          <= 1'b0;
            r_e0          <= 1'b0;
            r_v1          <= 1'b0;
            r_e1          <= 1'b0;
            valid_conv    <= 1'b0;
            end_conv      <= 1'b0;
            conv_op       <= '0;
        end else begin
            // The pipeline advances every cycle so latency is unaffected by input stalls.
            r_v0       <= w_accept && w_win_vld;
            r_e0       <= w_accept && w_win_last;
            r_v1       <= r_v0;
            r_e1       <= r_e0;
            valid_conv <= r_v1;
            end_conv   <= r_e1;
            if (r_v1) begin
                conv_op <= w_sum;
            end

            case (r_state)
                ST_LOAD: begin
                    if (w_valid) begin
                        if (r_w_idx == IW'(KK-1)) begin
                            r_w_idx <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_w_idx <= r_w_idx + IW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (r_col == CW'(N-1)) begin
                            r_col <= '0;
                            r_row <= (r_row == CW'(N-1)) ? '0 : r_row + CW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                    if (w_reload) begin
                        r_reload_pend <= 1'b1;
                    end
                    // Swap weights only between frames, once every in-flight result has left.
                    if (r_reload_pend && w_frame_start && w_drained) begin
                        r_reload_pend <= 1'b0;
                        r_state       <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Datapath: weight store, raster line buffer and per-tap multipliers.
    always_ff @(posedge clk) begin
        if ((r_state == ST_LOAD) && w_valid) begin
            r_wgt[r_w_idx] <= w_data;
        end
        if (w_accept) begin
            r_buf[0] <= in_data;
            for (int i = 1; i < L; i++) begin
                r_buf[i] <= r_buf[i-1];
            end
        end
        // r_buf[0] is the window's bottom-right pixel; tap (i,j) sits (K-1-i) rows and (K-1-j) columns back.
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                r_prod[i*K+j] <= r_buf[(K-1-i)*N + (K-1-j)] * r_wgt[i*K+j];
            end
        end
    end

endmodule
